// File: rtl/pipelined_rca_addsub_if.sv
// ----------------------------------------------------------------------------
// pipelined_rca_addsub_if
//
// Stream bundle for the pipelined ripple-carry adder/subtractor.
//
// Signals
//   a, b       WIDTH  operands
//   cin        1      carry-in (add) / borrow-in (subtract)
//   sub        1      0 = add, 1 = subtract
//   in_valid   1      producer offers an operation
//   in_ready   1      adder accepts an operation this cycle
//   sum        WIDTH  result
//   cout       1      raw carry-out of the MSB (subtract: 1 = no borrow)
//   ovf        1      signed two's-complement overflow
//   out_valid  1      sum/cout/ovf are valid
//   out_ready  1      consumer takes the result
//
// Modports
//   master  producer/consumer side (drives operands and out_ready)
//   slave   adder side
// ----------------------------------------------------------------------------
interface pipelined_rca_addsub_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, cin, sub, in_valid, out_ready,
        input  in_ready, sum, cout, ovf, out_valid
    );

    modport slave (
        input  a, b, cin, sub, in_valid, out_ready,
        output in_ready, sum, cout, ovf, out_valid
    );
endinterface

// File: rtl/pipelined_rca_addsub.sv
// ----------------------------------------------------------------------------
// pipelined_rca_addsub
//
// Parametrised pipelined ripple-carry adder/subtractor. The WIDTH-bit
// operation is cut into STAGES slices of SW = WIDTH/STAGES bits; stage k
// ripples slice k and registers the slice carry for stage k+1. Operands,
// partially built sum and mode travel down the pipe alongside the carry.
// Latency is STAGES cycles, throughput one operation per cycle, and a single
// global stall (out_valid & ~out_ready) freezes every stage.
//
// Parameters
//   WIDTH   operand/result width (>= 2)
//   STAGES  pipeline depth, must divide WIDTH
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; discards everything in flight
//   bus   slave side of pipelined_rca_addsub_if (operands, result, handshake)
// ----------------------------------------------------------------------------
module pipelined_rca_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pipelined_rca_addsub_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    // One pipeline entry. b is stored already inverted for subtract, so the
    // downstream stages never need to know the mode. cm is the carry into the
    // top bit of the slice just processed; only the last stage's copy matters
    // (it is the carry into the MSB used for the overflow flag).
    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             cm;
    } stage_t;

    logic   stall;
    stage_t in_st;

    // Subtract is a + ~b + ~cin: invert b and the incoming carry at capture.
    always_comb begin
        in_st.v  = bus.in_valid;
        in_st.a  = bus.a;
        in_st.b  = bus.sub ? ~bus.b : bus.b;
        in_st.s  = '0;
        in_st.c  = bus.sub ? ~bus.cin : bus.cin;
        in_st.cm = 1'b0;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t src;
        stage_t nxt;
        stage_t q;

        if (k == 0) begin : g_first
            assign src = in_st;
        end else begin : g_next
            assign src = g_stage[k-1].q;
        end

        // Full-adder ripple across bits [k*SW +: SW]; everything else passes.
        always_comb begin
            logic c;
            // NOTE: every variable is assigned before any conditional path so
            // no latch can be inferred in this combinational block.
            nxt = src;
            c   = src.c;
            for (int i = 0; i < SW; i++) begin
                nxt.cm           = c;
                nxt.s[k*SW + i]  = src.a[k*SW + i] ^ src.b[k*SW + i] ^ c;
                c                = (src.a[k*SW + i] & src.b[k*SW + i])
                                 | (c & (src.a[k*SW + i] ^ src.b[k*SW + i]));
            end
            nxt.c = c;
        end

        // NOTE: state registers use non-blocking assignments so every stage
        // samples its neighbour's pre-edge value.
        always_ff @(posedge clk) begin
            if (rst) begin
                // NOTE: data fields are reset too, not just the valid bit,
                // because the output stage must read all zeros during reset.
                q <= '0;
            end else if (!stall) begin
                q <= nxt;
            end
        end
    end

    assign stall         = g_stage[STAGES-1].q.v & ~bus.out_ready;
    assign bus.in_ready  = ~stall;

    assign bus.out_valid = g_stage[STAGES-1].q.v;
    assign bus.sum       = g_stage[STAGES-1].q.s;
    assign bus.cout      = g_stage[STAGES-1].q.c;
    assign bus.ovf       = g_stage[STAGES-1].q.cm ^ g_stage[STAGES-1].q.c;
endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// ----------------------------------------------------------------------------
// tb_pipelined_rca_addsub
//
// Three instances: (WIDTH 16, STAGES 4), (16, 1) and (8, 2). Directed tests
// run on the first; a long randomized mixed add/sub stream runs on all three.
// Each instance has a monitor that pushes the reference result on every
// accepted operation and pops/compares on every retired result, also checking
// latency and output stability during stalls.
// ----------------------------------------------------------------------------
module tb_pipelined_rca_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
        int          stalls;
    } exp_t;

    int errors = 0;
    int checks = 0;

    logic [15:0] a_d         [3];
    logic [15:0] b_d         [3];
    logic        cin_d       [3];
    logic        sub_d       [3];
    logic        in_valid_d  [3];
    logic        out_ready_d [3];

    logic [15:0] sum_w [3];
    logic        cout_w[3];
    logic        ovf_w [3];
    logic        ov_w  [3];
    logic        ir_w  [3];

    int pend    [3];
    int acc_cnt [3];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands' unsigned and
    // signed interpretations.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        exp_t   r;
        longint lim  = longint'(1) << (w - 1);
        longint mask = (lim * 2) - 1;
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = (ua >= lim) ? ua - 2 * lim : ua;
        longint sb   = (ub >= lim) ? ub - 2 * lim : ub;
        longint full;
        longint sres;
        if (!sub) begin
            full   = ua + ub + longint'(cin);
            sres   = sa + sb + longint'(cin);
            r.cout = (full >= 2 * lim);
        end else begin
            full   = ua - ub - longint'(cin);
            sres   = sa - sb - longint'(cin);
            r.cout = (full >= 0);
        end
        r.sum    = 16'(full & mask);
        r.ovf    = (sres < -lim) || (sres >= lim);
        r.cyc    = 0;
        r.stalls = 0;
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W = (g == 2) ? 8 : 16;
        localparam int S = (g == 0) ? 4 : ((g == 1) ? 1 : 2);

        pipelined_rca_addsub_if #(.WIDTH(W)) bus ();

        pipelined_rca_addsub #(.WIDTH(W), .STAGES(S)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.a         = a_d[g][W-1:0];
        assign bus.b         = b_d[g][W-1:0];
        assign bus.cin       = cin_d[g];
        assign bus.sub       = sub_d[g];
        assign bus.in_valid  = in_valid_d[g];
        assign bus.out_ready = out_ready_d[g];

        assign sum_w[g]  = 16'(bus.sum);
        assign cout_w[g] = bus.cout;
        assign ovf_w[g]  = bus.ovf;
        assign ov_w[g]   = bus.out_valid;
        assign ir_w[g]   = bus.in_ready;

        exp_t        q[$];
        int          cyc       = 0;
        int          stall_cnt = 0;
        logic        held      = 1'b0;
        logic [17:0] held_val;

        always @(negedge clk) begin
            exp_t e;
            if (rst) begin
                q.delete();
                held = 1'b0;
            end else begin
                if (held)
                    check($sformatf("cfg%0d hold_stable", g),
                          32'({bus.cout, bus.ovf, 16'(bus.sum)}), 32'(held_val));
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL cfg%0d unexpected_result: got sum %0h with no operation outstanding",
                                 g, bus.sum);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("cfg%0d sum", g), 32'(bus.sum), 32'(e.sum));
                        check($sformatf("cfg%0d cout_ovf", g), {30'd0, bus.cout, bus.ovf},
                              {30'd0, e.cout, e.ovf});
                        check($sformatf("cfg%0d latency", g), 32'(cyc - e.cyc),
                              32'(S + stall_cnt - e.stalls));
                    end
                end
                held = bus.out_valid && !bus.out_ready;
                if (held) begin
                    held_val = {bus.cout, bus.ovf, 16'(bus.sum)};
                    stall_cnt++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    e        = model(W, 16'(bus.a), 16'(bus.b), bus.cin, bus.sub);
                    e.cyc    = cyc;
                    e.stalls = stall_cnt;
                    q.push_back(e);
                    acc_cnt[g]++;
                end
            end
            pend[g] = q.size();
            cyc++;
        end
    end

    // Offer one operation to instance 0 and hold it until accepted.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        int n = 0;
        a_d[0]        = a;
        b_d[0]        = b;
        cin_d[0]      = cin;
        sub_d[0]      = sub;
        in_valid_d[0] = 1'b1;
        @(negedge clk);
        while (!ir_w[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        in_valid_d[0] = 1'b0;
    endtask

    task automatic drain(input int g);
        int n = 0;
        while (pend[g] != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout cfg%0d: %0d results outstanding, required 0", g, pend[g]);
        end
        #1;
    endtask

    initial begin
        int  n;
        bool_loop: begin end
        for (int g = 0; g < 3; g++) begin
            a_d[g] = '0; b_d[g] = '0; cin_d[g] = 1'b0; sub_d[g] = 1'b0;
            in_valid_d[g] = 1'b0; out_ready_d[g] = 1'b1;
            pend[g] = 0; acc_cnt[g] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("cfg%0d rst_out_valid", g), 32'(ov_w[g]), 32'd0);
            check($sformatf("cfg%0d rst_sum", g), 32'(sum_w[g]), 32'd0);
            check($sformatf("cfg%0d rst_flags", g), {30'd0, cout_w[g], ovf_w[g]}, 32'd0);
            check($sformatf("cfg%0d rst_in_ready", g), 32'(ir_w[g]), 32'd1);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: carry through every slice boundary, single-cycle out_valid
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        drain(0);
        @(negedge clk);
        check("t1_single_pulse", 32'(ov_w[0]), 32'd0);
        @(posedge clk);
        #1;

        // 2: signed overflow, then one slice-boundary carry, back-to-back
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h000F, 16'h0001, 1'b0, 1'b0);
        drain(0);

        // 3: subtract with borrow, overflow, and borrow-in
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h0009, 16'h0003, 1'b1, 1'b1);
        drain(0);

        // 4: streaming with a 3-cycle consumer stall
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready_d[0] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("t4_stall_in_ready", 32'(ir_w[0]), 32'd0);
                    check("t4_stall_out_valid", 32'(ov_w[0]), 32'd1);
                end
                @(posedge clk);
                #1 out_ready_d[0] = 1'b1;
            end
        join
        drain(0);

        // 5: reset mid-flight discards everything
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b0, 1'b1);
        send(16'h5555, 16'h6666, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("t5_no_output_after_rst", 32'(ov_w[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h00F0, 16'h0F10, 1'b0, 1'b0);
        drain(0);

        // 6: random mixed stream with bubbles and backpressure on all configs
        for (int g = 0; g < 3; g++) acc_cnt[g] = 0;
        n = 0;
        while (n < 20000 &&
               !(acc_cnt[0] >= 1000 && acc_cnt[1] >= 1000 && acc_cnt[2] >= 1000 &&
                 pend[0] == 0 && pend[1] == 0 && pend[2] == 0)) begin
            for (int g = 0; g < 3; g++) begin
                if (acc_cnt[g] < 1000) begin
                    a_d[g]         = 16'($urandom);
                    b_d[g]         = 16'($urandom);
                    cin_d[g]       = 1'($urandom);
                    sub_d[g]       = 1'($urandom);
                    in_valid_d[g]  = ($urandom_range(0, 3) != 0);
                    out_ready_d[g] = ($urandom_range(0, 3) != 0);
                end else begin
                    in_valid_d[g]  = 1'b0;
                    out_ready_d[g] = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL t6_timeout: accepted %0d/%0d/%0d pending %0d/%0d/%0d, required 1000 each and 0 pending",
                     acc_cnt[0], acc_cnt[1], acc_cnt[2], pend[0], pend[1], pend[2]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
